sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port wen  input  1  write request.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port ren  input  1  read request.
REQ-011 SHALL have port rdata  output  WIDTH  registered read data.
REQ-012 SHALL have port rvalid  output  1  rdata carries a newly read word this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have ports overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-016 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra logic.
REQ-017 Accepted write: wdata stored at waddr, waddr+1; accepted read: word at raddr to rdata next cycle with rvalid=1, raddr+1.
REQ-018 Read latency SHALL be exactly 1 cycle; rdata SHALL hold its last value when rvalid=0.
REQ-019 Count: +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds DEPTH, never wraps below 0.
REQ-020 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_LVL); almost_empty = (count<=AEMPTY_LVL); all combinational from registered count.
REQ-021 wen&&ren while empty: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-022 wen&&ren while full: both accepted, count stays DEPTH, no overflow.
REQ-023 ren while empty without wen: pointers unchanged, rvalid=0, underflow=1 next cycle.
REQ-024 wen while full without ren: handling per REQ-030/031; overflow=1 next cycle in both cases.
REQ-025 flush SHALL have priority over wen/ren: next cycle waddr=raddr=0, count=0, rvalid=0, no error pulse.

Reset
REQ-026 While rst_n=0: waddr=raddr=0, count=0, rvalid=0, rdata=0, overflow=underflow=0, independent of clk.
REQ-027 During reset, flags SHALL follow REQ-020: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Storage array contents SHALL NOT be reset.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer; the first post-reset read returns the first post-reset write.

Configuration
REQ-030 With SYNC_FIFO_OVERWRITE_EN defined: write when full overwrites the oldest entry, raddr+1, waddr+1, count stays DEPTH.
REQ-031 Without SYNC_FIFO_OVERWRITE_EN: write when full is dropped; storage and pointers unchanged.

Structure
REQ-032 Package sync_fifo_pkg SHALL hold the pointer/count width helper functions and the default parameter constants.
REQ-033 Storage SHALL be a sub-module fifo_ram (1 write port, 1 registered read port, WIDTH x DEPTH); pointer, count and flag logic stay in sync_fifo_param.

Verification
REQ-034 Reset, then 16 writes 0x01..0x10 (DEPTH=16): full=1, count=16, almost_full first high after 14th write.
REQ-035 From full, 16 reads: rdata 0x01..0x10 in order one cycle after each ren, then empty=1, count=0.
REQ-036 From full, write 0xAA, no read: overwrite build reads 0x02..0x10,0xAA; drop build reads 0x01..0x10; overflow pulses once in both.
REQ-037 Empty, simultaneous wen(0x55)+ren: underflow=1, count=1; next read returns 0x55.
REQ-038 With count=5, flush: next cycle count=0, empty=1, no error pulse; rst_n low mid-burst: all outputs reach reset values without a clk edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared width helpers and default parameters for sync_fifo_param
package sync_fifo_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AEMPTY_LVL = 2;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so the occupancy can represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - WIDTH x DEPTH storage, one write port, one registered read port
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is intentionally left unreset; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with flags and error pulses
// Define SYNC_FIFO_OVERWRITE_EN to let a write into a full FIFO replace the oldest entry.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wen,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    ren,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [AW-1:0] waddr, raddr;
  logic          ovw, do_write, do_read, inc, dec;

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

`ifdef SYNC_FIFO_OVERWRITE_EN
  assign ovw = !flush && wen && !ren && full;
`else
  assign ovw = 1'b0;
`endif

  // Full with a concurrent read frees a slot, so the write is taken as well.
  assign do_write = !flush && wen && (!full || ren || ovw);
  assign do_read  = !flush && ren && !empty;
  assign inc      = do_write && !do_read && !ovw;
  assign dec      = do_read && !do_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr     <= '0;
      raddr     <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      waddr     <= '0;
      raddr     <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_write)           waddr <= waddr + 1'b1;
      if (do_read || ovw)     raddr <= raddr + 1'b1;
      if (inc)                count <= count + 1'b1;
      else if (dec)           count <= count - 1'b1;
      rvalid    <= do_read;
      overflow  <= wen && !ren && full;
      underflow <= ren && empty;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .waddr (waddr),
    .wdata (wdata),
    .re    (do_read),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             wen = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             ren = 1'b0;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
    wen = w; wdata = d; ren = r; flush = f;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_aempty"}, 32'(almost_empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_rvalid"}, 32'(rvalid), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
  endtask

  initial begin
    logic [7:0] exp_d;

    #3;
    chk_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      chk($sformatf("fill_afull_%0d", i), 32'(almost_full), (i >= 14) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_empty", 32'(empty), 0);

    // Write while full, no read.
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_once", 32'(overflow), 0);

    // Drain all sixteen entries.
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_OVERWRITE_EN
      exp_d = (i < DEPTH - 1) ? 8'(i + 2) : 8'hAA;
`else
      exp_d = 8'(i + 1);
`endif
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain_rvalid_%0d", i), 32'(rvalid), 1);
      chk($sformatf("drain_rdata_%0d", i), 32'(rdata), 32'(exp_d));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_rvalid", 32'(rvalid), 0);
    chk("idle_rdata_hold", 32'(rdata), 32'(exp_d));

    // Read from empty.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_rvalid", 32'(rvalid), 0);
    chk("udf_count", 32'(count), 0);

    // Simultaneous write and read while empty.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("wr_empty_udf", 32'(underflow), 1);
    chk("wr_empty_count", 32'(count), 1);
    chk("wr_empty_rvalid", 32'(rvalid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wr_empty_rdata", 32'(rdata), 32'h55);
    chk("wr_empty_rvalid2", 32'(rvalid), 1);
    chk("wr_empty_udf_clr", 32'(underflow), 0);

    // Full with both requests: both accepted.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("refill_full", 32'(full), 1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw_rdata", 32'(rdata), 32'h20);
    chk("full_rw_count", 32'(count), 16);
    chk("full_rw_ovf", 32'(overflow), 0);

    // Drain down to five entries, then flush with competing requests.
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_flush_count", 32'(count), 5);
    chk("pre_flush_rdata", 32'(rdata), 32'h2B);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_rvalid", 32'(rvalid), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_udf", 32'(underflow), 0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_rdata", 32'(rdata), 32'h33);

    // Reset in the middle of a burst, without a clock edge.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    cyc(1'b1, 8'h43, 1'b1, 1'b0);
    chk("burst_rvalid", 32'(rvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_rdata", 32'(rdata), 32'h99);
    chk("post_reset_count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
